tick_timer: RTL and testbench

- Programmable down-count timer, directly downstream of the free-running counter.
- Consumes the counter's overflow as a one-cycle tick strobe and counts a programmable number of ticks.
- Then raises a one-cycle expire pulse plus a sticky interrupt.
- Supports one-shot and periodic (auto-reload) modes, start/stop control and overrun detection.

---
 rtl/tick_timer.sv | 114 +++++++++++
 tb/tb_tick_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// Programmable tick down-counter: counts tick_in strobes from a reload value,
// pulses expire on completion and keeps a sticky irq/overrun pair.
module tick_timer #(
  parameter int LOAD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_in,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [LOAD_W-1:0] load_val,
  input  logic              irq_ack,
  output logic              busy,
  output logic [LOAD_W-1:0] cur_val,
  output logic              expire,
  output logic              irq,
  output logic              overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_reg,   state_next;
  logic [LOAD_W-1:0] reload_reg,  reload_next;
  logic [LOAD_W-1:0] cur_reg,     cur_next;
  logic              mode_reg,    mode_next;
  logic              expire_reg,  expire_next;
  logic              irq_reg,     irq_next;
  logic              overrun_reg, overrun_next;

  logic load_ok;
  assign load_ok = (load_val != '0);

  always_comb begin
    state_next  = state_reg;
    reload_next = reload_reg;
    cur_next    = cur_reg;
    mode_next   = mode_reg;
    expire_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!stop && start && load_ok) begin
          reload_next = load_val;
          cur_next    = load_val;
          mode_next   = mode;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (start) begin
          // A zero-length restart cannot run, so it behaves as a stop.
          if (load_ok) begin
            reload_next = load_val;
            cur_next    = load_val;
            mode_next   = mode;
          end else begin
            state_next = IDLE;
          end
        end else if (tick_in) begin
          if (cur_reg > LOAD_W'(1)) begin
            cur_next = cur_reg - LOAD_W'(1);
          end else if (cur_reg == LOAD_W'(1)) begin
            expire_next = 1'b1;
            if (mode_reg) begin
              cur_next = reload_reg;
            end else begin
              cur_next   = '0;
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A new expire landing on a still-pending irq is an overrun even if the
    // ack arrives in the same cycle; the set always beats the clear.
    irq_next     = expire_next | (irq_reg & ~irq_ack);
    overrun_next = (expire_next & irq_reg) | (overrun_reg & ~irq_ack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      reload_reg  <= '0;
      cur_reg     <= '0;
      mode_reg    <= 1'b0;
      expire_reg  <= 1'b0;
      irq_reg     <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      reload_reg  <= reload_next;
      cur_reg     <= cur_next;
      mode_reg    <= mode_next;
      expire_reg  <= expire_next;
      irq_reg     <= irq_next;
      overrun_reg <= overrun_next;
    end
  end

  assign busy    = (state_reg == RUN);
  assign cur_val = cur_reg;
  assign expire  = expire_reg;
  assign irq     = irq_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: a period-level reference model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_tick_timer;

  localparam int LOAD_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick_in = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              mode = 1'b0;
  logic [LOAD_W-1:0] load_val = '0;
  logic              irq_ack = 1'b0;
  logic              busy;
  logic [LOAD_W-1:0] cur_val;
  logic              expire;
  logic              irq;
  logic              overrun;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  tick_timer #(.LOAD_W(LOAD_W)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
    .mode(mode), .load_val(load_val), .irq_ack(irq_ack), .busy(busy),
    .cur_val(cur_val), .expire(expire), .irq(irq), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: a timer is either running or not, with some ticks left.
  bit m_running, m_periodic, m_exp, m_irq, m_ovr;
  int m_left, m_reload;

  always @(posedge clk or posedge rst) begin
    bit done;
    if (rst) begin
      m_running = 0; m_periodic = 0; m_exp = 0; m_irq = 0; m_ovr = 0;
      m_left = 0; m_reload = 0;
    end else begin
      done = 0;
      if (stop) begin
        m_running = 0;
      end else if (start) begin
        if (load_val != 0) begin
          m_running = 1; m_left = load_val; m_reload = load_val; m_periodic = mode;
        end else begin
          m_running = 0;
        end
      end else if (tick_in && m_running) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          done = 1;
          if (m_periodic) m_left = m_reload;
          else m_running = 0;
        end
      end
      m_exp = done;
      m_ovr = (done && m_irq) || (m_ovr && !irq_ack);
      m_irq = done || (m_irq && !irq_ack);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_busy",    int'(busy),    int'(m_running));
      chk("model_cur_val", int'(cur_val), m_left);
      chk("model_expire",  int'(expire),  int'(m_exp));
      chk("model_irq",     int'(irq),     int'(m_irq));
      chk("model_overrun", int'(overrun), int'(m_ovr));
    end
  end

  // One clock of stimulus; pulses drop back to 0 just after the edge.
  task automatic step(input bit t, input bit s, input bit p, input bit m,
                      input int lv, input bit a);
    tick_in = t; start = s; stop = p; mode = m; load_val = LOAD_W'(lv); irq_ack = a;
    @(posedge clk);
    #1;
    $display("txn tick=%0b start=%0b stop=%0b mode=%0b load=%0d ack=%0b -> busy=%0b cur=%0d exp=%0b irq=%0b ovr=%0b",
             t, s, p, m, lv, a, busy, cur_val, expire, irq, overrun);
    tick_in = 0; start = 0; stop = 0; irq_ack = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  int exp_cur[6] = '{1, 2, 1, 2, 1, 2};
  int exp_exp[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_en = 1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_cur", int'(cur_val), 0);
    chk("reset_irq", int'(irq), 0);

    // start with zero load is ignored in IDLE
    step(0, 1, 0, 0, 0, 0);
    chk("zero_load_busy", int'(busy), 0);
    chk("zero_load_cur", int'(cur_val), 0);

    // one-shot, load 3, ticks 4 cycles apart
    step(0, 1, 0, 0, 3, 0);
    chk("oneshot_load", int'(cur_val), 3);
    step(1, 0, 0, 0, 0, 0); chk("oneshot_t1", int'(cur_val), 2); idle(3);
    step(1, 0, 0, 0, 0, 0); chk("oneshot_t2", int'(cur_val), 1); idle(3);
    step(1, 0, 0, 0, 0, 0);
    chk("oneshot_expire", int'(expire), 1);
    chk("oneshot_cur0", int'(cur_val), 0);
    chk("oneshot_irq", int'(irq), 1);
    chk("oneshot_idle", int'(busy), 0);
    idle(1);
    chk("expire_one_cycle", int'(expire), 0);
    step(1, 0, 0, 0, 0, 0);
    chk("idle_tick_ignored", int'(cur_val), 0);
    step(0, 0, 0, 0, 0, 1);
    chk("ack_clears_irq", int'(irq), 0);

    // periodic, load 2, tick held high 6 cycles
    step(0, 1, 0, 1, 2, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("periodic_cur", int'(cur_val), exp_cur[i]);
      chk("periodic_expire", int'(expire), exp_exp[i]);
      chk("periodic_busy", int'(busy), 1);
      if (i == 1) chk("no_overrun_first", int'(overrun), 0);
      if (i == 3) chk("overrun_second", int'(overrun), 1);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("ack_irq", int'(irq), 0);
    chk("ack_overrun", int'(overrun), 0);
    step(0, 0, 1, 0, 0, 0);

    // periodic load 5: stop beats the final tick
    step(0, 1, 0, 1, 5, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("stop_no_expire", int'(expire), 0);
    chk("stop_holds_cur", int'(cur_val), 1);
    chk("stop_idle", int'(busy), 0);
    step(0, 1, 0, 0, 4, 0);
    chk("restart_cur", int'(cur_val), 4);
    chk("restart_busy", int'(busy), 1);
    step(0, 0, 1, 0, 0, 0);

    // restart mid-run with a coincident tick, then zero-load restart = stop
    step(0, 1, 0, 0, 9, 0);
    step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
    chk("pre_restart_cur", int'(cur_val), 7);
    step(1, 1, 0, 0, 10, 0);
    chk("restart_no_dec", int'(cur_val), 10);
    step(1, 1, 0, 0, 0, 0);
    chk("zero_restart_stops", int'(busy), 0);
    chk("zero_restart_hold", int'(cur_val), 10);

    // periodic load 1: ack coinciding with a new expire
    step(0, 1, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("load1_expire", int'(expire), 1);
    chk("load1_cur", int'(cur_val), 1);
    step(1, 0, 0, 0, 0, 1);
    chk("ack_vs_expire_irq", int'(irq), 1);
    chk("ack_vs_expire_ovr", int'(overrun), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("ack_next_irq", int'(irq), 0);
    chk("ack_next_ovr", int'(overrun), 0);
    step(0, 0, 1, 0, 0, 0);

    // async reset mid-period with irq pending
    step(0, 1, 0, 1, 10, 0);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 0, 0);
    chk("pre_rst_cur", int'(cur_val), 9);
    chk("pre_rst_irq", int'(irq), 1);
    #2 rst = 1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_cur", int'(cur_val), 0);
    chk("async_rst_irq", int'(irq), 0);
    chk("async_rst_expire", int'(expire), 0);
    chk("async_rst_ovr", int'(overrun), 0);
    @(posedge clk);
    #3 rst = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    chk("post_rst_tick_ignored", int'(cur_val), 0);
    chk("post_rst_idle", int'(busy), 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
